// File: rtl/c2_cfg_loader.sv
// Bit-serial configuration loader for a bank of C2 cells: shift into a shadow register, then commit atomically to cfg_o.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit after each frame.
module c2_cfg_loader #(
  parameter int N_CELLS = 4,
  parameter int CFG_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic                       cfg_bit_i,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [N_CELLS*CFG_W-1:0]   cfg_o
);

  localparam int W     = N_CELLS * CFG_W;
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef PARITY_CHECK_EN
    ST_COMMIT = 2'd2,
    ST_PARITY = 2'd3
`else
    ST_COMMIT = 2'd2
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       shadow_q, shadow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       cfg_q, cfg_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic               accept;

  // A transfer needs the registered ready; abort takes priority over any bit.
  assign accept = cfg_valid_i && ready_q && !abort_i;

`ifdef PARITY_CHECK_EN
  logic err_q, err_d;
  logic parity_ok;

  function automatic logic frame_parity(input logic [W-1:0] data, input logic pbit);
    return ^{data, pbit};
  endfunction

  assign parity_ok = (frame_parity(shadow_q, cfg_bit_i) == 1'b0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      cfg_q    <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      cfg_q    <= cfg_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (accept && (cnt_q == LAST_BIT)) begin
`ifdef PARITY_CHECK_EN
          state_d = ST_PARITY;
`else
          state_d = ST_COMMIT;
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      ST_PARITY: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          state_d = parity_ok ? ST_COMMIT : ST_IDLE;
        end
      end
`endif
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath logic; cfg_d only moves away from cfg_q in COMMIT.
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    cfg_d    = cfg_q;
    done_d   = 1'b0;
`ifdef PARITY_CHECK_EN
    err_d    = err_q;
    ready_d  = (state_d == ST_SHIFT) || (state_d == ST_PARITY);
`else
    ready_d  = (state_d == ST_SHIFT);
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          cnt_d = '0;
`ifdef PARITY_CHECK_EN
          err_d = 1'b0;
`endif
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          shadow_d = {shadow_q[W-2:0], cfg_bit_i};
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
`ifdef PARITY_CHECK_EN
      ST_PARITY: begin
        if (accept && !parity_ok) err_d = 1'b1;
      end
`endif
      ST_COMMIT: begin
        cfg_d  = shadow_q;
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  assign cfg_ready_o = ready_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign cfg_o       = cfg_q;
`ifdef PARITY_CHECK_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_c2_cfg_loader.sv
// Self-checking bench for c2_cfg_loader (two cells, 16-bit frames) with randomized streams and stalls.
module tb_c2_cfg_loader;

  localparam int NC = 2;
  localparam int W  = NC * 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic         abort_i;
  logic         cfg_bit_i;
  logic         cfg_valid_i;
  logic         cfg_ready_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;
  logic [W-1:0] cfg_o;

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] cfg_exp;

  c2_cfg_loader #(.N_CELLS(NC), .CFG_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .cfg_bit_i   (cfg_bit_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .cfg_o       (cfg_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted bit, optionally preceded by a stall cycle carrying a wrong bit.
  task automatic push_bit(input logic b, input bit stall, input logic st);
    if (stall) begin
      cfg_valid_i = 1'b0;
      cfg_bit_i   = ~b;
      start_i     = st;
      tick();
    end
    cfg_valid_i = 1'b1;
    cfg_bit_i   = b;
    start_i     = st;
    tick();
    cfg_valid_i = 1'b0;
    start_i     = 1'b0;
  endtask

  // Even parity over data plus parity bit: parity bit equals the data's ones-count mod 2.
  function automatic logic good_parity(input logic [W-1:0] d);
    return logic'($countones(d) % 2);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; cfg_bit_i = 1'b0; cfg_valid_i = 1'b0;
    repeat (3) tick();
    n_checks++; if (cfg_o !== '0) $display("FAIL reset_cfg: got %h want 0", cfg_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
    n_checks++; if (cfg_ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", cfg_ready_o); else n_pass++;
    n_checks++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", done_o); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy_o); else n_pass++;
    cfg_exp = '0;
  endtask

  // Full load: the stream is sent MSB first, so the committed word equals d.
  task automatic test_stream(input logic [W-1:0] d, input bit rnd, input bit abort_commit, input string tag);
    logic [W-1:0] old;
    old = cfg_exp;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n_checks++; if (busy_o !== 1'b1) $display("FAIL %s start_busy: got %b want 1", tag, busy_o); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("FAIL %s start_err: got %b want 0", tag, err_o); else n_pass++;
    for (int i = W - 1; i >= 0; i--) begin
      n_checks++; if (cfg_ready_o !== 1'b1) $display("FAIL %s ready_shift bit %0d: got %b want 1", tag, i, cfg_ready_o); else n_pass++;
      n_checks++; if (cfg_o !== old) $display("FAIL %s cfg_during_shift: got %h want %h", tag, cfg_o, old); else n_pass++;
      push_bit(d[i], rnd ? 1'($urandom_range(0, 1)) : 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b0);
    end
`ifdef PARITY_CHECK_EN
    n_checks++; if (cfg_ready_o !== 1'b1) $display("FAIL %s ready_parity: got %b want 1", tag, cfg_ready_o); else n_pass++;
    push_bit(good_parity(d), 1'b0, 1'b0);
`endif
    n_checks++; if (done_o !== 1'b0) $display("FAIL %s early_done: got %b want 0", tag, done_o); else n_pass++;
    n_checks++; if (cfg_o !== old) $display("FAIL %s early_cfg: got %h want %h", tag, cfg_o, old); else n_pass++;
    n_checks++; if (cfg_ready_o !== 1'b0) $display("FAIL %s ready_commit: got %b want 0", tag, cfg_ready_o); else n_pass++;
    abort_i = abort_commit;
    tick();
    abort_i = 1'b0;
    cfg_exp = d;
    n_checks++; if (done_o !== 1'b1) $display("FAIL %s done_pulse: got %b want 1", tag, done_o); else n_pass++;
    n_checks++; if (cfg_o !== cfg_exp) $display("FAIL %s cfg_commit: got %h want %h", tag, cfg_o, cfg_exp); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL %s busy_after: got %b want 0", tag, busy_o); else n_pass++;
    tick();
    n_checks++; if (done_o !== 1'b0) $display("FAIL %s done_width: got %b want 0", tag, done_o); else n_pass++;
    n_checks++; if (cfg_o !== cfg_exp) $display("FAIL %s cfg_hold: got %h want %h", tag, cfg_o, cfg_exp); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("FAIL %s err_clean: got %b want 0", tag, err_o); else n_pass++;
  endtask

  task automatic test_cell_slices();
    test_stream(16'h5AC3, 1'b0, 1'b0, "slices");
    n_checks++; if (cfg_o[15:8] !== 8'h5A) $display("FAIL cell1_slice: got %h want 5a", cfg_o[15:8]); else n_pass++;
    n_checks++; if (cfg_o[7:0] !== 8'hC3) $display("FAIL cell0_slice: got %h want c3", cfg_o[7:0]); else n_pass++;
  endtask

  task automatic test_abort(input int nbits, input string tag);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < nbits; i++) push_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    abort_i     = 1'b1;
    cfg_valid_i = 1'b1;
    cfg_bit_i   = 1'($urandom_range(0, 1));
    tick();
    abort_i     = 1'b0;
    cfg_valid_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL %s busy: got %b want 0", tag, busy_o); else n_pass++;
    n_checks++; if (cfg_ready_o !== 1'b0) $display("FAIL %s ready: got %b want 0", tag, cfg_ready_o); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (done_o !== 1'b0) $display("FAIL %s done: got %b want 0", tag, done_o); else n_pass++;
      n_checks++; if (cfg_o !== cfg_exp) $display("FAIL %s cfg: got %h want %h", tag, cfg_o, cfg_exp); else n_pass++;
      tick();
    end
  endtask

  task automatic test_start_abort_idle();
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL start_abort_busy: got %b want 0", busy_o); else n_pass++;
    n_checks++; if (cfg_ready_o !== 1'b0) $display("FAIL start_abort_ready: got %b want 0", cfg_ready_o); else n_pass++;
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity_error();
    logic [W-1:0] d;
    d = W'($urandom());
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = W - 1; i >= 0; i--) push_bit(d[i], 1'b0, 1'b0);
    push_bit(~good_parity(d), 1'b0, 1'b0);
    n_checks++; if (err_o !== 1'b1) $display("FAIL parity_err_set: got %b want 1", err_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL parity_err_busy: got %b want 0", busy_o); else n_pass++;
    n_checks++; if (done_o !== 1'b0) $display("FAIL parity_err_done: got %b want 0", done_o); else n_pass++;
    tick();
    n_checks++; if (cfg_o !== cfg_exp) $display("FAIL parity_err_cfg: got %h want %h", cfg_o, cfg_exp); else n_pass++;
    n_checks++; if (done_o !== 1'b0) $display("FAIL parity_err_done2: got %b want 0", done_o); else n_pass++;
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_checks++; if (err_o !== 1'b1) $display("FAIL parity_err_sticky: got %b want 1", err_o); else n_pass++;
    tick();
    start_i = 1'b0;
    n_checks++; if (err_o !== 1'b0) $display("FAIL parity_err_clear: got %b want 0", err_o); else n_pass++;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
  endtask
`endif

  task automatic test_async_reset();
    test_stream(16'hFFFF, 1'b0, 1'b0, "pre_reset");
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) push_bit(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (cfg_o !== '0) $display("FAIL async_rst_cfg: got %h want 0", cfg_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL async_rst_busy: got %b want 0", busy_o); else n_pass++;
    n_checks++; if (cfg_ready_o !== 1'b0) $display("FAIL async_rst_ready: got %b want 0", cfg_ready_o); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    cfg_exp = '0;
    tick();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL async_rst_idle: got %b want 0", busy_o); else n_pass++;
    n_checks++; if (done_o !== 1'b0) $display("FAIL async_rst_done: got %b want 0", done_o); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream(16'hA3A3, 1'b0, 1'b0, "directed_a3");
    test_stream(16'hA3A3, 1'b1, 1'b0, "stalled_a3");
    test_cell_slices();
    for (int r = 0; r < 6; r++) test_stream(W'($urandom()), 1'b1, 1'b0, "random");
    test_stream(W'($urandom()), 1'b1, 1'b1, "abort_in_commit");
    test_abort(4, "abort_mid");
    test_abort(W - 1, "abort_last_bit");
    test_start_abort_idle();
`ifdef PARITY_CHECK_EN
    test_parity_error();
`endif
    test_stream(W'($urandom()), 1'b0, 1'b0, "recover");
    test_async_reset();
    test_stream(W'($urandom()), 1'b1, 1'b0, "after_reset");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
